// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared types and elaboration helpers for the Booth/Wallace multiplier
package mul_pkg;

    typedef enum logic [1:0] {
        MUL_LO  = 2'b00,
        MULH_SS = 2'b01,
        MULH_SU = 2'b10,
        MULH_UU = 2'b11
    } mul_op_e;

    typedef enum logic [2:0] {ZERO, P1, P2, N1, N2} booth_sel_e;

    localparam int TAG_MAX_W = 16;

    typedef struct packed {
        logic                 v;
        mul_op_e              op;
        logic [TAG_MAX_W-1:0] tag;
    } stage_t;

    function automatic int npp(input int width);
        return width / 2 + 1;
    endfunction

    // One Wallace layer turns every full group of three rows into two.
    function automatic int rows_after(input int n, input int layers);
        int r = n;
        for (int l = 0; l < layers; l++) begin
            r = r - r / 3;
        end
        return r;
    endfunction

    function automatic int csa_layers(input int n, input int target = 2);
        int r = n;
        int l = 0;
        while (r > target) begin
            r = r - r / 3;
            l++;
        end
        return l;
    endfunction

endpackage

// File: rtl/mul_booth_pp.sv
// rtl/mul_booth_pp.sv - radix-4 Booth partial product with sign-prefix and negate bit
module mul_booth_pp
    import mul_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH+1:0] m_ext_i,
    input  logic [2:0]       win_i,
    output logic [WIDTH+2:0] pp_o,
    output logic             neg_o
);

    booth_sel_e       sel;
    logic [WIDTH+2:0] mag;
    logic [WIDTH+2:0] raw;

    always_comb begin
        case (win_i)
            3'b001, 3'b010: sel = P1;
            3'b011:         sel = P2;
            3'b100:         sel = N2;
            3'b101, 3'b110: sel = N1;
            default:        sel = ZERO;
        endcase
        mag = '0;
        case (sel)
            P1, N1:  mag = {m_ext_i[WIDTH+1], m_ext_i};
            P2, N2:  mag = {m_ext_i, 1'b0};
            default: mag = '0;
        endcase
        neg_o = (sel == N1) || (sel == N2);
        raw   = neg_o ? ~mag : mag;
        // Inverted sign bit; the matching constant row restores the sign extension.
        pp_o  = {~raw[WIDTH+2], raw[WIDTH+1:0]};
    end

endmodule

// File: rtl/booth_wallace_mul_pipe.sv
// rtl/booth_wallace_mul_pipe.sv - 3-stage radix-4 Booth / Wallace-tree multiplier with flush
module booth_wallace_mul_pipe
    import mul_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic [1:0]         op_i,
    input  logic [WIDTH-1:0]   rs1_i,
    input  logic [WIDTH-1:0]   rs2_i,
    input  logic [TAG_W-1:0]   tag_i,
    input  logic               flush_i,
    output logic [WIDTH-1:0]   result_o,
    output logic [2*WIDTH-1:0] product_o,
    output logic [TAG_W-1:0]   tag_o,
    output logic               valid_o,
    output logic               busy_o
);

    localparam int XW    = WIDTH + 2;
    localparam int PPW   = WIDTH + 3;
    localparam int PW    = 2 * WIDTH;
    localparam int NPP   = npp(WIDTH);
    localparam int NROWS = NPP + 2;
    localparam int LS2   = csa_layers(NROWS, 4);
    localparam int R2    = rows_after(NROWS, LS2);
    localparam int LS3   = csa_layers(R2, 2);

    function automatic logic [PW-1:0] sign_fix();
        logic [PW-1:0] acc = '0;
        for (int j = 0; j < NPP; j++) begin
            acc = acc + (PW'(1) << (PPW - 1 + 2 * j));
        end
        return -acc;
    endfunction

    localparam logic [PW-1:0] SIGN_FIX = sign_fix();

    function automatic logic [2*PW-1:0] csa3(input logic [PW-1:0] a, input logic [PW-1:0] b,
                                             input logic [PW-1:0] c);
        logic [PW-1:0] maj;
        logic [PW-1:0] cy;
        maj = (a & b) | (a & c) | (b & c);
        cy  = {maj[PW-2:0], 1'b0};
        return {cy, a ^ b ^ c};
    endfunction

    mul_op_e       op_in;
    stage_t        s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
    logic [XW-1:0] a_q, a_d, b_q, b_d;
    logic [XW:0]   b_win;
    logic [PW-1:0] s2_rows_q [R2];
    logic [PW-1:0] s2_rows_d [R2];
    logic [PW-1:0] s2_tree [R2];
    logic [PW-1:0] init_rows [NROWS];
    logic [PW-1:0] neg_row;
    logic [PPW-1:0] pp [NPP];
    logic [NPP-1:0] pp_neg;
    logic [PW-1:0]    final_sum;
    logic [PW-1:0]    product_q, product_d;
    logic [WIDTH-1:0] result_q, result_d;

    assign op_in = mul_op_e'(op_i);

    always_comb begin
        s1_d   = s1_q;
        a_d    = a_q;
        b_d    = b_q;
        s1_d.v = start_i;
        if (start_i) begin
            s1_d.op  = op_in;
            s1_d.tag = TAG_MAX_W'(tag_i);
            a_d = (op_in == MULH_UU) ? {2'b00, rs1_i} : {{2{rs1_i[WIDTH-1]}}, rs1_i};
            b_d = (op_in == MUL_LO || op_in == MULH_SS) ? {{2{rs2_i[WIDTH-1]}}, rs2_i}
                                                        : {2'b00, rs2_i};
        end
    end

    assign b_win = {b_q, 1'b0};

    for (genvar j = 0; j < NPP; j++) begin : g_pp
        mul_booth_pp #(.WIDTH(WIDTH)) u_pp (
            .m_ext_i (a_q),
            .win_i   (b_win[2*j+2:2*j]),
            .pp_o    (pp[j]),
            .neg_o   (pp_neg[j])
        );
    end

    always_comb begin
        neg_row = '0;
        for (int j = 0; j < NPP; j++) begin
            init_rows[j]     = PW'(pp[j]) << (2 * j);
            neg_row[2 * j]   = pp_neg[j];
        end
        init_rows[NPP]     = neg_row;
        init_rows[NPP + 1] = SIGN_FIX;
    end

    // Everything is modulo 2^PW, so carries out of the top column are simply dropped.
    for (genvar l = 0; l <= LS2; l++) begin : g_s2
        localparam int RN = rows_after(NROWS, l);
        logic [PW-1:0] rows [RN];
        if (l == 0) begin : g_src
            assign rows = init_rows;
        end else begin : g_lay
            localparam int RP = rows_after(NROWS, l - 1);
            for (genvar g = 0; g < RP / 3; g++) begin : g_csa
                assign {rows[2*g+1], rows[2*g]} =
                    csa3(g_s2[l-1].rows[3*g], g_s2[l-1].rows[3*g+1], g_s2[l-1].rows[3*g+2]);
            end
            for (genvar r = 3 * (RP / 3); r < RP; r++) begin : g_pass
                assign rows[r - RP / 3] = g_s2[l-1].rows[r];
            end
        end
    end

    assign s2_tree = g_s2[LS2].rows;

    always_comb begin
        s2_d      = s2_q;
        s2_rows_d = s2_rows_q;
        s2_d.v    = s1_q.v & ~flush_i;
        if (s1_q.v) begin
            s2_d.op   = s1_q.op;
            s2_d.tag  = s1_q.tag;
            s2_rows_d = s2_tree;
        end
    end

    for (genvar l = 0; l <= LS3; l++) begin : g_s3
        localparam int RN = rows_after(R2, l);
        logic [PW-1:0] rows [RN];
        if (l == 0) begin : g_src
            assign rows = s2_rows_q;
        end else begin : g_lay
            localparam int RP = rows_after(R2, l - 1);
            for (genvar g = 0; g < RP / 3; g++) begin : g_csa
                assign {rows[2*g+1], rows[2*g]} =
                    csa3(g_s3[l-1].rows[3*g], g_s3[l-1].rows[3*g+1], g_s3[l-1].rows[3*g+2]);
            end
            for (genvar r = 3 * (RP / 3); r < RP; r++) begin : g_pass
                assign rows[r - RP / 3] = g_s3[l-1].rows[r];
            end
        end
    end

    assign final_sum = g_s3[LS3].rows[0] + g_s3[LS3].rows[1];

    always_comb begin
        s3_d      = s3_q;
        product_d = product_q;
        result_d  = result_q;
        s3_d.v    = s2_q.v & ~flush_i;
        if (s2_q.v && !flush_i) begin
            s3_d.op   = s2_q.op;
            s3_d.tag  = s2_q.tag;
            product_d = final_sum;
            result_d  = (s2_q.op == MUL_LO) ? final_sum[WIDTH-1:0] : final_sum[PW-1:WIDTH];
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            s1_q      <= '0;
            s2_q      <= '0;
            s3_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            product_q <= '0;
            result_q  <= '0;
            for (int i = 0; i < R2; i++) begin
                s2_rows_q[i] <= '0;
            end
        end else begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            s3_q      <= s3_d;
            a_q       <= a_d;
            b_q       <= b_d;
            product_q <= product_d;
            result_q  <= result_d;
            for (int i = 0; i < R2; i++) begin
                s2_rows_q[i] <= s2_rows_d[i];
            end
        end
    end

    assign result_o  = result_q;
    assign product_o = product_q;
    assign tag_o     = s3_q.tag[TAG_W-1:0];
    assign valid_o   = s3_q.v;
    assign busy_o    = s1_q.v | s2_q.v | s3_q.v;

endmodule

// File: tb/tb_booth_wallace_mul_pipe.sv
// tb/tb_booth_wallace_mul_pipe.sv - directed table and pipeline sequences for the multiplier
module tb_booth_wallace_mul_pipe;

    localparam int W  = 32;
    localparam int TW = 5;
    localparam int NV = 15;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [63:0] prod;
    } vec_t;

    typedef struct {
        logic        v;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  tag;
    } mstage_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n, start, flush;
    logic [1:0]      op;
    logic [W-1:0]    rs1, rs2;
    logic [TW-1:0]   tag;
    logic [W-1:0]    result;
    logic [2*W-1:0]  product;
    logic [TW-1:0]   tag_out;
    logic            valid, busy;
    logic [7:0]      result8;
    logic [15:0]     product8;
    logic [TW-1:0]   tag_out8;
    logic            valid8, busy8;

    booth_wallace_mul_pipe #(.WIDTH(W), .TAG_W(TW)) u_dut (
        .clk_i(clk), .rst_i(rst_n), .start_i(start), .op_i(op), .rs1_i(rs1), .rs2_i(rs2),
        .tag_i(tag), .flush_i(flush), .result_o(result), .product_o(product),
        .tag_o(tag_out), .valid_o(valid), .busy_o(busy)
    );

    booth_wallace_mul_pipe #(.WIDTH(8), .TAG_W(TW)) u_dut8 (
        .clk_i(clk), .rst_i(rst_n), .start_i(start), .op_i(op), .rs1_i(rs1[7:0]),
        .rs2_i(rs2[7:0]), .tag_i(tag), .flush_i(flush), .result_o(result8),
        .product_o(product8), .tag_o(tag_out8), .valid_o(valid8), .busy_o(busy8)
    );

    int      n_pass = 0;
    int      n_total = 0;
    int      seen;
    vec_t    vecs [NV];
    int      b2b [4] = '{0, 2, 3, 4};
    mstage_t m1, m2, m3;
    logic        s_r, f_r;
    logic [1:0]  o_r;
    logic [31:0] a_r, b_r;
    logic [4:0]  t_r;
    logic [63:0] p_exp;
    logic [15:0] p8_exp;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] t, input logic f);
        start = s; op = o; rs1 = a; rs2 = b; tag = t; flush = f;
    endtask

    function automatic logic [63:0] ref32(input logic [1:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [63:0] ea, eb;
        ea = (o == 2'b11) ? {32'b0, a} : {{32{a[31]}}, a};
        eb = o[1] ? {32'b0, b} : {{32{b[31]}}, b};
        return ea * eb;
    endfunction

    function automatic logic [15:0] ref8(input logic [1:0] o, input logic [7:0] a,
                                         input logic [7:0] b);
        logic [15:0] ea, eb;
        ea = (o == 2'b11) ? {8'b0, a} : {{8{a[7]}}, a};
        eb = o[1] ? {8'b0, b} : {{8{b[7]}}, b};
        return ea * eb;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(5))
            0:       return 32'h8000_0080;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h7FFF_FF7F;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{2'b00, 32'd7,         32'd6,         32'd42,        64'd42};
        vecs[1]  = '{2'b01, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'h00000000,  64'h1};
        vecs[2]  = '{2'b11, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'hFFFFFFFE,  64'hFFFFFFFE_00000001};
        vecs[3]  = '{2'b10, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'hFFFFFFFF,  64'hFFFFFFFF_00000001};
        vecs[4]  = '{2'b01, 32'h80000000,  32'h80000000,  32'h40000000,  64'h40000000_00000000};
        vecs[5]  = '{2'b00, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'h00000001,  64'h1};
        vecs[6]  = '{2'b10, 32'h80000000,  32'h80000000,  32'hC0000000,  64'hC0000000_00000000};
        vecs[7]  = '{2'b11, 32'h80000000,  32'h80000000,  32'h40000000,  64'h40000000_00000000};
        vecs[8]  = '{2'b01, 32'h80000000,  32'h7FFFFFFF,  32'hC0000000,  64'hC0000000_80000000};
        vecs[9]  = '{2'b11, 32'h00010000,  32'h00010000,  32'h00000001,  64'h00000001_00000000};
        vecs[10] = '{2'b01, 32'hFFFFFFFD,  32'd5,         32'hFFFFFFFF,  64'hFFFFFFFF_FFFFFFF1};
        vecs[11] = '{2'b00, 32'hFFFFFFFD,  32'd5,         32'hFFFFFFF1,  64'hFFFFFFFF_FFFFFFF1};
        vecs[12] = '{2'b10, 32'hFFFFFFFD,  32'h80000000,  32'hFFFFFFFE,  64'hFFFFFFFE_80000000};
        vecs[13] = '{2'b11, 32'hFFFFFFFF,  32'd2,         32'h00000001,  64'h00000001_FFFFFFFE};
        vecs[14] = '{2'b00, 32'h0,         32'hFFFFFFFF,  32'h00000000,  64'h0};

        rst_n = 1'b0;
        drive(0, 2'b00, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_valid", valid, 0);
        check("reset_busy", busy, 0);
        check("reset_result", result, 0);
        check("reset_product", product, 0);
        check("reset_tag", tag_out, 0);
        check("reset_valid8", valid8, 0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < NV; i++) begin
            drive(1, vecs[i].op, vecs[i].a, vecs[i].b, TW'(i), 0);
            tick();
            start = 1'b0;
            check("vec_valid_e0", valid, 0);
            if (i == 0) check("vec_busy_s1", busy, 1);
            tick();
            check("vec_valid_e1", valid, 0);
            if (i == 0) check("vec_busy_s2", busy, 1);
            tick();
            check("vec_valid", valid, 1);
            check("vec_result", result, vecs[i].res);
            check("vec_product", product, vecs[i].prod);
            check("vec_tag", tag_out, TW'(i));
            if (i == 0) check("vec_busy_s3", busy, 1);
            tick();
            check("vec_valid_drop", valid, 0);
            if (i == 0) check("vec_busy_idle", busy, 0);
        end

        for (int c = 0; c < 7; c++) begin
            if (c < 4) drive(1, vecs[b2b[c]].op, vecs[b2b[c]].a, vecs[b2b[c]].b, TW'(c + 1), 0);
            tick();
            start = 1'b0;
            if (c >= 2 && c <= 5) begin
                check("b2b_valid", valid, 1);
                check("b2b_tag", tag_out, TW'(c - 1));
                check("b2b_result", result, vecs[b2b[c-2]].res);
                check("b2b_product", product, vecs[b2b[c-2]].prod);
            end else begin
                check("b2b_idle", valid, 0);
            end
        end

        for (int c = 0; c < 6; c++) begin
            if (c < 2) drive(1, vecs[c+1].op, vecs[c+1].a, vecs[c+1].b, TW'(20 + c), 0);
            else if (c == 2) drive(1, vecs[0].op, vecs[0].a, vecs[0].b, 5'd9, 1);
            tick();
            start = 1'b0;
            flush = 1'b0;
            if (c == 2) check("flush_busy", busy, 1);
            if (c == 4) begin
                check("flush_valid", valid, 1);
                check("flush_tag", tag_out, 9);
                check("flush_result", result, 42);
            end else begin
                check("flush_killed", valid, 0);
            end
        end

        drive(1, vecs[4].op, vecs[4].a, vecs[4].b, 5'd11, 0);
        tick();
        drive(1, vecs[5].op, vecs[5].a, vecs[5].b, 5'd12, 0);
        tick();
        start = 1'b0;
        tick();
        check("rst_pre_valid", valid, 1);
        check("rst_pre_tag", tag_out, 11);
        #2 rst_n = 1'b0;
        #1;
        check("rst_valid_drop", valid, 0);
        check("rst_busy_drop", busy, 0);
        check("rst_product_clear", product, 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (6) begin
            tick();
            if (valid || busy) seen++;
        end
        check("rst_no_ghost", seen, 0);

        m1 = '{1'b0, 2'b0, 32'b0, 32'b0, 5'b0};
        m2 = m1;
        m3 = m1;
        for (int c = 0; c < 600; c++) begin
            s_r = ($urandom_range(3) != 0);
            f_r = ($urandom_range(15) == 0);
            o_r = 2'($urandom_range(3));
            a_r = pick();
            b_r = pick();
            t_r = 5'($urandom_range(31));
            drive(s_r, o_r, a_r, b_r, t_r, f_r);
            @(posedge clk);
            m3   = m2;
            m3.v = m2.v & ~f_r;
            m2   = m1;
            m2.v = m1.v & ~f_r;
            m1   = '{s_r, o_r, a_r, b_r, t_r};
            #1;
            check("rnd_valid", valid, m3.v);
            check("rnd_valid8", valid8, m3.v);
            if (m3.v) begin
                p_exp  = ref32(m3.op, m3.a, m3.b);
                p8_exp = ref8(m3.op, m3.a[7:0], m3.b[7:0]);
                check("rnd_product", product, p_exp);
                check("rnd_result", result, (m3.op == 2'b00) ? p_exp[31:0] : p_exp[63:32]);
                check("rnd_tag", tag_out, m3.tag);
                check("rnd_product8", product8, p8_exp);
                check("rnd_result8", result8, (m3.op == 2'b00) ? p8_exp[7:0] : p8_exp[15:8]);
                check("rnd_tag8", tag_out8, m3.tag);
            end
        end
        drive(0, 2'b00, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
